// File: rtl/video_mnist_number_vote.sv
// video_mnist_number_vote: sliding-window majority vote over per-pixel MNIST classes, 2-stage pipeline.
// Optional VIDEO_MNIST_NUMBER_VOTE_MASK_EN: pixels with tbinary=0 enter the window as "no vote".
module video_mnist_number_vote #(
   parameter int TUSER_WIDTH   = 1,
   parameter int TDATA_WIDTH   = 24,
   parameter int TNUMBER_WIDTH = 4,
   parameter int TCOUNT_WIDTH  = 4,
   parameter int WINDOW        = 8
) (
   input  logic                     aresetn,
   input  logic                     aclk,
   input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
   input  logic                     s_axi4s_tlast,
   input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
   input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
   input  logic                     s_axi4s_tbinary,
   input  logic                     s_axi4s_tvalid,
   output logic                     s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
   output logic                     m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
   output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
   output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
   output logic                     m_axi4s_tbinary,
   output logic                     m_axi4s_tvalid,
   input  logic                     m_axi4s_tready
);
   localparam logic [TNUMBER_WIDTH-1:0] INV = '1;
   localparam logic [TCOUNT_WIDTH-1:0]  WIN = TCOUNT_WIDTH'(WINDOW);

   logic [TNUMBER_WIDTH-1:0] hist [WINDOW];
   logic [TCOUNT_WIDTH-1:0]  cnt [10];
   logic [TCOUNT_WIDTH-1:0]  cnt_next [10];
   logic                     clear_pending;
   logic                     s0_valid, s0_last, s0_binary;
   logic [TUSER_WIDTH-1:0]   s0_user;
   logic [TDATA_WIDTH-1:0]   s0_data;
   logic [TNUMBER_WIDTH-1:0] num, oldest, best_num;
   logic [TCOUNT_WIDTH-1:0]  best_cnt;
   logic                     adv, fresh;

   assign adv            = m_axi4s_tready || !m_axi4s_tvalid;
   assign s_axi4s_tready = adv;
`ifdef VIDEO_MNIST_NUMBER_VOTE_MASK_EN
   assign num = s_axi4s_tbinary ? s_axi4s_tnumber : INV;
`else
   assign num = s_axi4s_tnumber;
`endif
   assign oldest = hist[WINDOW-1];
   assign fresh  = clear_pending || s_axi4s_tuser[0];

   // A class that is both entering and leaving keeps its count.
   always_comb begin
      for (int i = 0; i < 10; i++) begin
         cnt_next[i] = cnt[i];
         if (fresh)
            cnt_next[i] = (num == TNUMBER_WIDTH'(i)) ? TCOUNT_WIDTH'(1) : '0;
         else if (num == TNUMBER_WIDTH'(i) && oldest != TNUMBER_WIDTH'(i))
            cnt_next[i] = (cnt[i] == WIN) ? cnt[i] : cnt[i] + 1'b1;
         else if (oldest == TNUMBER_WIDTH'(i) && num != TNUMBER_WIDTH'(i))
            cnt_next[i] = (cnt[i] == '0) ? cnt[i] : cnt[i] - 1'b1;
      end
   end

   // Strict greater-than keeps the lowest class on ties.
   always_comb begin
      best_num = '0;
      best_cnt = '0;
      for (int i = 0; i < 10; i++) begin
         if (cnt[i] > best_cnt) begin
            best_num = TNUMBER_WIDTH'(i);
            best_cnt = cnt[i];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < WINDOW; i++) hist[i] <= INV;
         for (int i = 0; i < 10; i++) cnt[i] <= '0;
         clear_pending   <= 1'b1;
         s0_valid        <= 1'b0;
         s0_last         <= 1'b0;
         s0_binary       <= 1'b0;
         s0_user         <= '0;
         s0_data         <= '0;
         m_axi4s_tvalid  <= 1'b0;
         m_axi4s_tuser   <= '0;
         m_axi4s_tlast   <= 1'b0;
         m_axi4s_tnumber <= '0;
         m_axi4s_tcount  <= '0;
         m_axi4s_tdata   <= '0;
         m_axi4s_tbinary <= 1'b0;
      end else if (adv) begin
         s0_valid        <= s_axi4s_tvalid;
         s0_last         <= s_axi4s_tlast;
         s0_binary       <= s_axi4s_tbinary;
         s0_user         <= s_axi4s_tuser;
         s0_data         <= s_axi4s_tdata;
         m_axi4s_tvalid  <= s0_valid;
         m_axi4s_tuser   <= s0_user;
         m_axi4s_tlast   <= s0_last;
         m_axi4s_tdata   <= s0_data;
         m_axi4s_tbinary <= s0_binary;
         m_axi4s_tnumber <= best_num;
         m_axi4s_tcount  <= best_cnt;
         if (s_axi4s_tvalid) begin
            for (int i = 0; i < 10; i++) cnt[i] <= cnt_next[i];
            hist[0] <= num;
            for (int i = 1; i < WINDOW; i++) hist[i] <= fresh ? INV : hist[i-1];
            clear_pending <= s_axi4s_tlast;
         end
      end
   end
endmodule

// File: tb/tb_video_mnist_number_vote.sv
// tb_video_mnist_number_vote: scoreboard bench for the sliding-window class vote.
// Expected votes come from a window model that recounts the whole window per pixel.
module tb_video_mnist_number_vote;
   localparam int WINDOW = 8;

   typedef struct packed {
      logic [3:0]  num;
      logic [3:0]  cnt;
      logic        last;
      logic        user;
      logic        binary;
      logic [23:0] data;
   } vote_t;

   logic        aclk, aresetn;
   logic [0:0]  s_tuser, m_tuser;
   logic        s_tlast, s_tbinary, s_tvalid, s_tready;
   logic [3:0]  s_tnumber, m_tnumber, m_tcount;
   logic [23:0] s_tdata, m_tdata;
   logic        m_tlast, m_tbinary, m_tvalid, m_tready;

   video_mnist_number_vote #(.WINDOW(WINDOW)) dut (
      .aresetn(aresetn), .aclk(aclk),
      .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tnumber(s_tnumber),
      .s_axi4s_tdata(s_tdata), .s_axi4s_tbinary(s_tbinary), .s_axi4s_tvalid(s_tvalid),
      .s_axi4s_tready(s_tready),
      .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
      .m_axi4s_tcount(m_tcount), .m_axi4s_tdata(m_tdata), .m_axi4s_tbinary(m_tbinary),
      .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int    vectors = 0, miscompares = 0;
   int    cyc = 0, first_acc = -1, first_out = -1;
   int    mh[$];
   logic  clr = 1'b1;
   logic  last_acc, cur_valid, cur_ready;
   vote_t cur, e, o;
   vote_t exp_q[$], obs_q[$];

   function automatic void model(input logic [3:0] n, input logic u, input logic l,
                                 input logic b, input logic [23:0] d);
      int ev, bn, bc;
      int c[10];
      vote_t v;
      ev = n;
`ifdef VIDEO_MNIST_NUMBER_VOTE_MASK_EN
      if (!b) ev = 15;
`endif
      if (clr || u) mh.delete();
      mh.push_back(ev);
      if (mh.size() > WINDOW) void'(mh.pop_front());
      for (int i = 0; i < 10; i++) c[i] = 0;
      foreach (mh[i]) if (mh[i] < 10) c[mh[i]]++;
      bn = 0; bc = 0;
      for (int i = 0; i < 10; i++) if (c[i] > bc) begin bn = i; bc = c[i]; end
      clr = l;
      v.num = 4'(bn); v.cnt = 4'(bc); v.last = l; v.user = u; v.binary = b; v.data = d;
      exp_q.push_back(v);
   endfunction

   task automatic cycle();
      vote_t ov;
      logic acc, outv, u, l, b;
      logic [3:0] n;
      logic [23:0] d;
      @(negedge aclk);
      acc = s_tvalid && s_tready;
      outv = m_tvalid && m_tready;
      n = s_tnumber; u = s_tuser[0]; l = s_tlast; b = s_tbinary; d = s_tdata;
      ov.num = m_tnumber; ov.cnt = m_tcount; ov.last = m_tlast; ov.user = m_tuser[0];
      ov.binary = m_tbinary; ov.data = m_tdata;
      cur = ov; cur_valid = m_tvalid; cur_ready = s_tready;
      @(posedge aclk);
      if (acc) begin model(n, u, l, b, d); if (first_acc < 0) first_acc = cyc; end
      if (outv) begin obs_q.push_back(ov); if (first_out < 0) first_out = cyc; end
      last_acc = acc;
      cyc++;
      #1;
   endtask

   task automatic send(input int n, input logic u, input logic l, input logic b);
      int k = 0;
      s_tnumber = 4'(n); s_tuser = u; s_tlast = l; s_tbinary = b;
      s_tdata = 24'($urandom); s_tvalid = 1'b1;
      do begin cycle(); k++; end while (!last_acc && k < 50);
      if (!last_acc) begin
         miscompares++;
         $display("FAIL accept_timeout: pixel %0d not accepted, required accept within 50 cycles", n);
      end
   endtask

   task automatic drain();
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
      for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) cycle();
      repeat (2) cycle();
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL out_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0; m_tready = 1'b1; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
      s_tnumber = '0; s_tdata = '0; s_tbinary = 1'b1;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      clr = 1'b1; mh.delete();
      vectors++;
      if ({m_tvalid, m_tnumber, m_tcount, m_tlast, m_tdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b n=%0d c=%0d, required all 0", m_tvalid, m_tnumber, m_tcount);
      end
      vectors++;
      if (s_tready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b, required 1", s_tready);
      end
   endtask

   task automatic test_ramp();
      first_acc = -1; first_out = -1;
      for (int i = 0; i < 8; i++) send(3, i == 0, 1'b0, 1'b1);
      drain();
      vectors++;
      if (first_out - first_acc != 2) begin
         miscompares++;
         $display("FAIL ramp_latency: got %0d cycles, required 2", first_out - first_acc);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e || o.num !== 4'd3 || o.cnt !== 4'(i + 1)) begin
            miscompares++;
            $display("FAIL ramp[%0d]: got %h, required %h (num 3 cnt %0d)", i, o, e, i + 1);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_tie();
      for (int i = 0; i < 5; i++) send(5, 1'b0, 1'b0, 1'b1);
      drain();
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e || (i == 3 && {o.num, o.cnt} !== {4'd3, 4'd4}) ||
             (i == 4 && {o.num, o.cnt} !== {4'd5, 4'd5})) begin
            miscompares++;
            $display("FAIL tie[%0d]: got %h, required %h", i, o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_line();
      for (int i = 0; i < 8; i++) send(3, i == 0, i == 7, 1'b1);
      send(7, 1'b0, 1'b0, 1'b1);
      drain();
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e || o.last !== (i == 7) ||
             (i == 8 && {o.num, o.cnt} !== {4'd7, 4'd1})) begin
            miscompares++;
            $display("FAIL line[%0d]: got %h, required %h", i, o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_invalid();
      for (int i = 0; i < 8; i++) send(12, i == 0, 1'b0, 1'b1);
      send(4, 1'b0, 1'b0, 1'b1);
      drain();
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e || {o.num, o.cnt} !== ((i == 8) ? {4'd4, 4'd1} : 8'd0)) begin
            miscompares++;
            $display("FAIL invalid[%0d]: got %h, required %h", i, o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_stall();
      int pat[12] = '{1, 1, 2, 2, 2, 9, 9, 0, 0, 0, 0, 3};
      for (int i = 0; i < 4; i++) send(pat[i], i == 0, 1'b0, 1'b1);
      s_tnumber = 4'(pat[4]); s_tuser = 1'b0; s_tdata = 24'h5a5a5a; s_tvalid = 1'b1;
      m_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         vectors++;
         if (cur_ready !== 1'b0 || cur_valid !== 1'b1 || cur !== exp_q[obs_q.size()]) begin
            miscompares++;
            $display("FAIL stall[%0d]: got rdy=%b v=%b %h, required rdy=0 v=1 %h",
                     k, cur_ready, cur_valid, cur, exp_q[obs_q.size()]);
         end
      end
      m_tready = 1'b1;
      for (int i = 4; i < 12; i++) send(pat[i], 1'b0, 1'b0, 1'b1);
      drain();
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL stall_seq[%0d]: got %h, required %h", i, o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) send(8, i == 0, 1'b0, 1'b1);
      s_tvalid = 1'b0;
      vectors++;
      if (m_tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_valid: got %b, required 1", m_tvalid);
      end
      #2 aresetn = 1'b0;
      #1;
      vectors++;
      if ({m_tvalid, m_tnumber, m_tcount} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b n=%0d c=%0d, required 0 0 0", m_tvalid, m_tnumber, m_tcount);
      end
      @(posedge aclk);
      #1 aresetn = 1'b1;
      exp_q.delete(); obs_q.delete(); mh.delete(); clr = 1'b1;
      send(2, 1'b0, 1'b0, 1'b1);
      drain();
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e || {o.num, o.cnt} !== {4'd2, 4'd1}) begin
            miscompares++;
            $display("FAIL post_reset: got %h, required %h", o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_mask();
      for (int i = 0; i < 8; i++) send(6, i == 0, 1'b0, 1'b0);
      drain();
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         logic [7:0] want;
`ifdef VIDEO_MNIST_NUMBER_VOTE_MASK_EN
         want = 8'd0;
`else
         want = {4'd6, 4'(i + 1)};
`endif
         e = exp_q.pop_front(); o = obs_q.pop_front();
         vectors++;
         if (o !== e || {o.num, o.cnt} !== want) begin
            miscompares++;
            $display("FAIL mask[%0d]: got %h, required %h", i, o, e);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_tie();
      test_line();
      test_invalid();
      test_stall();
      test_async_reset();
      test_mask();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
